// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer slice.
// State encodings and the per-pass step limit.
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MAX_STEP = 3;

endpackage

// File: rtl/shift_pass.sv
// One combinational shift/rotate pass of 0..3 positions.
// Built as repeated single-bit moves so any DATA_W>=2 works.
module shift_pass #(
    parameter int DATA_W = 4
) (
    input  logic [1:0]        en_amt,
    input  logic              left,
    input  logic              rotate,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] t;

    // Apply up to three one-position moves, zero-fill or wrap.
    always_comb begin
        t = i_data;
        for (int i = 0; i < 3; i++) begin
            if (i < int'(en_amt)) begin
                if (left) begin
                    t = {t[DATA_W-2:0], rotate ? t[DATA_W-1] : 1'b0};
                end else begin
                    t = {rotate ? t[0] : 1'b0, t[DATA_W-1:1]};
                end
            end
        end
        o_data = t;
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: splits a request into
// passes of at most three positions, one pass per clock.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int AMT_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_left,
    input  logic              i_rotate,
    input  logic [AMT_W-1:0]  i_amt,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy
);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] pass_data;
    logic [AMT_W-1:0]  rem;
    logic [AMT_W-1:0]  rem_nxt;
    logic              left_q;
    logic              rot_q;
    logic [1:0]        step;
    logic              last_step;
    logic              accept;

    shift_pass #(
        .DATA_W (DATA_W)
    ) u_pass (
        .en_amt (step),
        .left   (left_q),
        .rotate (rot_q),
        .i_data (data_q),
        .o_data (pass_data)
    );

    // Pick this pass's step; step never exceeds rem.
    always_comb begin
        step = 2'(MAX_STEP);
        if (rem < AMT_W'(MAX_STEP)) begin
            step = rem[1:0];
        end
        rem_nxt   = rem - AMT_W'(step);
        last_step = (rem_nxt == '0);
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs decoded from state.
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        o_busy    = 1'b0;
        accept    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    accept    = 1'b1;
                    state_nxt = (i_amt != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (last_step) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
                if (i_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture request, iterate passes, latch result on entry to DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q <= '0;
            out_q  <= '0;
            rem    <= '0;
            left_q <= 1'b0;
            rot_q  <= 1'b0;
        end else if (accept) begin
            data_q <= i_data;
            rem    <= i_amt;
            left_q <= i_left;
            rot_q  <= i_rotate;
            if (i_amt == '0) begin
                out_q <= i_data;
            end
        end else if (state == ST_RUN) begin
            data_q <= pass_data;
            rem    <= rem_nxt;
            if (last_step) begin
                out_q <= pass_data;
            end
        end
    end

    assign o_data = out_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer (DATA_W=4, AMT_W=4).
// Vector table plus hand sequences for backpressure and reset.
module tb_shift_sequencer;

    logic       i_clk;
    logic       i_rst;
    logic       i_valid;
    logic       o_ready;
    logic       i_left;
    logic       i_rotate;
    logic [3:0] i_amt;
    logic [3:0] i_data;
    logic       o_valid;
    logic       i_ready;
    logic [3:0] o_data;
    logic       o_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       left;
        logic       rot;
        logic [3:0] amt;
        logic [3:0] data;
        logic [3:0] exp;
        int         lat;
    } vec_t;

    vec_t vecs[14];

    shift_sequencer #(
        .DATA_W (4),
        .AMT_W  (4)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_left   (i_left),
        .i_rotate (i_rotate),
        .i_amt    (i_amt),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_busy   (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        @(negedge i_clk);
        chk($sformatf("v%0d ready", idx), int'(o_ready), 1);
        i_valid  = 1'b1;
        i_left   = v.left;
        i_rotate = v.rot;
        i_amt    = v.amt;
        i_data   = v.data;
        i_ready  = 1'b0;
        tick();
        i_valid  = 1'b0;
        i_left   = ~v.left;
        i_rotate = ~v.rot;
        i_amt    = 4'hF;
        i_data   = ~v.data;
        lat = 1;
        while (!o_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d data", idx), int'(o_data), int'(v.exp));
        @(negedge i_clk);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk($sformatf("v%0d idle", idx), int'(o_valid), 0);
    endtask

    initial begin
        logic [3:0] held;
        int         lat;
        //          left rot  amt    data     exp      lat
        vecs[0]  = '{1'b1, 1'b0, 4'd2,  4'b0011, 4'b1100, 2};
        vecs[1]  = '{1'b1, 1'b0, 4'd5,  4'b0001, 4'b0000, 3};
        vecs[2]  = '{1'b1, 1'b1, 4'd5,  4'b0001, 4'b0010, 3};
        vecs[3]  = '{1'b0, 1'b1, 4'd7,  4'b1000, 4'b0001, 4};
        vecs[4]  = '{1'b0, 1'b0, 4'd15, 4'b1111, 4'b0000, 6};
        vecs[5]  = '{1'b1, 1'b0, 4'd0,  4'b1010, 4'b1010, 1};
        vecs[6]  = '{1'b0, 1'b0, 4'd1,  4'b1010, 4'b0101, 2};
        vecs[7]  = '{1'b1, 1'b1, 4'd3,  4'b1001, 4'b1100, 2};
        vecs[8]  = '{1'b0, 1'b1, 4'd4,  4'b0110, 4'b0110, 3};
        vecs[9]  = '{1'b1, 1'b0, 4'd3,  4'b0001, 4'b1000, 2};
        vecs[10] = '{1'b0, 1'b0, 4'd6,  4'b1111, 4'b0000, 3};
        vecs[11] = '{1'b1, 1'b1, 4'd15, 4'b0011, 4'b1001, 6};
        vecs[12] = '{1'b0, 1'b1, 4'd2,  4'b1011, 4'b1110, 2};
        vecs[13] = '{1'b1, 1'b0, 4'd4,  4'b1111, 4'b0000, 3};

        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_left   = 1'b0;
        i_rotate = 1'b0;
        i_amt    = '0;
        i_data   = '0;
        i_ready  = 1'b0;
        tick();
        tick();
        chk("rst ready", int'(o_ready), 1);
        chk("rst valid", int'(o_valid), 0);
        chk("rst busy", int'(o_busy), 0);
        chk("rst data", int'(o_data), 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_vec(i, vecs[i]);
        end

        // Pending request while busy, then backpressure in DONE.
        @(negedge i_clk);
        i_valid  = 1'b1;
        i_left   = 1'b1;
        i_rotate = 1'b1;
        i_amt    = 4'd4;
        i_data   = 4'b0001;
        tick();
        i_amt    = 4'd0;
        i_data   = 4'b0101;
        i_left   = 1'b0;
        i_rotate = 1'b0;
        chk("bp busy", int'(o_busy), 1);
        lat = 1;
        while (!o_valid && lat < 40) begin
            chk($sformatf("bp noaccept %0d", lat), int'(o_ready), 0);
            tick();
            lat++;
        end
        chk("bp latency", lat, 3);
        chk("bp data", int'(o_data), 4'b0001);
        held = o_data;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("bp hold valid %0d", c), int'(o_valid), 1);
            chk($sformatf("bp hold data %0d", c), int'(o_data), int'(held));
            chk($sformatf("bp hold ready %0d", c), int'(o_ready), 0);
        end
        @(negedge i_clk);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("bp ready after hs", int'(o_ready), 1);
        chk("bp valid after hs", int'(o_valid), 0);
        tick();
        i_valid = 1'b0;
        chk("pend valid", int'(o_valid), 1);
        chk("pend data", int'(o_data), 4'b0101);
        @(negedge i_clk);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("pend idle", int'(o_ready), 1);

        // Reset in the middle of a long run.
        @(negedge i_clk);
        i_valid  = 1'b1;
        i_left   = 1'b1;
        i_rotate = 1'b0;
        i_amt    = 4'd9;
        i_data   = 4'b1111;
        tick();
        i_valid = 1'b0;
        tick();
        chk("mid busy", int'(o_busy), 1);
        @(negedge i_clk);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("abort valid", int'(o_valid), 0);
        chk("abort busy", int'(o_busy), 0);
        chk("abort ready", int'(o_ready), 1);
        chk("abort data", int'(o_data), 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("abort quiet %0d", c), int'(o_valid), 0);
        end
        run_vec(20, vecs[3]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
